// File: rtl/m_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
package m_unit_pkg;

    localparam int unsigned XLEN = 32;

    // RV32M func3 encodings
    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/m_unit_divider.sv
// Iterative radix-2 restoring divider core operating on unsigned magnitudes.
// quotient/remainder present the value after the step taken at the next edge,
// so the final step's outcome can be captured on the same edge it completes.
module m_divider
    import m_unit_pkg::*;
#(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic [4:0]      count,
    output logic            last
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN:0]   shifted;
    logic            ge;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        ge        = (shifted >= {1'b0, dsr_q});
        quotient  = {quo_q[XLEN-2:0], ge};
        remainder = ge ? XLEN'(shifted - {1'b0, dsr_q}) : shifted[XLEN-1:0];
        last      = (count == LAST_ITER);
    end

    // Load operands on start, otherwise advance one iteration per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            count <= '0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
            count <= '0;
        end else if (step) begin
            quo_q <= quotient;
            rem_q <= remainder;
            count <= count + 5'd1;
        end
    end

endmodule

// File: rtl/m_unit.sv
// RV32M multiply/divide execute unit: single-cycle multiply, iterative divide,
// special-case division resolved at accept.
module m_unit
    import m_unit_pkg::*;
#(
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            div_signed;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            q_neg_q;
    logic            r_neg_q;

    logic [XLEN:0]   a_ext;
    logic [XLEN:0]   b_ext;
    logic signed [63:0] prod;
    logic [XLEN-1:0] mul_res;

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [4:0]      div_count;
    logic            div_last;
    logic [XLEN-1:0] div_res;

    // Accept decode, operand magnitudes and special-case division results.
    always_comb begin
        accept     = start && !flush && (state == ST_IDLE || state == ST_DONE);
        div_signed = !func3[0];
        mag_a      = (div_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
        mag_b      = (div_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
        div_zero   = (rs2_val == '0);
        div_ovf    = div_signed && (rs1_val == 32'h8000_0000) && (rs2_val == '1);
        special    = func3[2] && (div_zero || div_ovf);
        if (div_zero)
            special_res = func3[1] ? rs1_val : '1;
        else
            special_res = func3[1] ? '0 : 32'h8000_0000;
    end

    // Multiplier on latched operands, with per-op 33-bit extension.
    always_comb begin
        a_ext   = {(op_q != M_MULHU) && a_q[XLEN-1], a_q};
        b_ext   = {((op_q == M_MUL) || (op_q == M_MULH)) && b_q[XLEN-1], b_q};
        prod    = $signed({{31{a_ext[XLEN]}}, a_ext}) * $signed({{31{b_ext[XLEN]}}, b_ext});
        mul_res = (op_q == M_MUL) ? prod[31:0] : prod[63:32];
    end

    // Sign fix-up of the divider's magnitude results.
    always_comb begin
        if ((op_q == M_REM) || (op_q == M_REMU))
            div_res = r_neg_q ? -rem : rem;
        else
            div_res = q_neg_q ? -quo : quo;
    end

    m_divider #(
        .DIV_ITERS (DIV_ITERS)
    ) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && func3[2] && !special),
        .step      (state == ST_DIV),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (quo),
        .remainder (rem),
        .count     (div_count),
        .last      (div_last)
    );

    // Latch operation and operands on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (accept) begin
            op_q    <= func3;
            a_q     <= rs1_val;
            b_q     <= rs2_val;
            q_neg_q <= div_signed && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
            r_neg_q <= div_signed && rs1_val[XLEN-1];
        end
    end

    // Result register, written on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            result <= '0;
        else if (accept && special)
            result <= special_res;
        else if (state == ST_MUL && !flush)
            result <= mul_res;
        else if (state == ST_DIV && div_last && !flush)
            result <= div_res;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (accept)
                    state_nxt = !func3[2] ? ST_MUL : (special ? ST_DONE : ST_DIV);
            end
            ST_MUL:  state_nxt = ST_DONE;
            ST_DIV:  if (div_count == LAST_ITER) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush)
            state_nxt = ST_IDLE;
        busy = (state == ST_MUL) || (state == ST_DIV);
        done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_m_unit.sv
// Directed self-checking bench for m_unit.
`timescale 1ns/1ps
module tb_m_unit;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    m_unit #(
        .DIV_ITERS (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .func3   (func3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (start held for cycle T), scramble inputs afterwards, and
    // record the cycle offset of done, the number of busy cycles and result.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int done_at, output int busy_n, output logic [31:0] res);
        start   = 1'b1;
        func3   = f;
        rs1_val = a;
        rs2_val = b;
        tick();
        start   = 1'b0;
        func3   = ~f;
        rs1_val = ~a;
        rs2_val = ~b;
        done_at = -1;
        busy_n  = 0;
        res     = 32'hxxxx_xxxx;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            if (busy) busy_n++;
            if (done) begin
                done_at = c;
                res     = result;
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; func3 = '0; rs1_val = '0; rs2_val = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        #2 rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_mul();
        int d, b;
        logic [31:0] r;
        run_op(F_MUL, 32'd7, 32'hFFFF_FFFD, d, b, r);
        checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h expected ffffffeb", r); end
        checks++; if (d != 2) begin errors++; $display("FAIL mul_done_cycle: got %0d expected 2", d); end
        checks++; if (b != 1) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 1", b); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b expected 0", done); end
        checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_hold: got %h expected ffffffeb", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mul_high();
        logic [2:0]  fv [3] = '{F_MULH, F_MULHU, F_MULHSU};
        logic [31:0] av [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int d, b;
        logic [31:0] r;
        for (int i = 0; i < 3; i++) begin
            run_op(fv[i], av[i], bv[i], d, b, r);
            checks++; if (r !== ev[i]) begin errors++; $display("FAIL mulhi_result[%0d]: got %h expected %h", i, r, ev[i]); end
            checks++; if (d != 2) begin errors++; $display("FAIL mulhi_done_cycle[%0d]: got %0d expected 2", i, d); end
            tick();
        end
    endtask

    task automatic test_div();
        logic [2:0]  fv [4] = '{F_DIV, F_REM, F_DIVU, F_REMU};
        logic [31:0] ev [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
        int d, b;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            run_op(fv[i], 32'hFFFF_FFF9, 32'd2, d, b, r);
            checks++; if (r !== ev[i]) begin errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, r, ev[i]); end
            checks++; if (d != 33) begin errors++; $display("FAIL div_done_cycle[%0d]: got %0d expected 33", i, d); end
            checks++; if (b != 32) begin errors++; $display("FAIL div_busy_cycles[%0d]: got %0d expected 32", i, b); end
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL div_done_pulse[%0d]: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  fv [4] = '{F_DIVU, F_REM, F_DIV, F_REM};
        logic [31:0] av [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int d, b;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            run_op(fv[i], av[i], bv[i], d, b, r);
            checks++; if (r !== ev[i]) begin errors++; $display("FAIL special_result[%0d]: got %h expected %h", i, r, ev[i]); end
            checks++; if (d != 1) begin errors++; $display("FAIL special_done_cycle[%0d]: got %0d expected 1", i, d); end
            checks++; if (b != 0) begin errors++; $display("FAIL special_busy_cycles[%0d]: got %0d expected 0", i, b); end
            tick();
        end
    endtask

    task automatic test_flush();
        int d, b, late_done;
        logic [31:0] r;
        // flush mid-divide
        start = 1'b1; func3 = F_DIVU; rs1_val = 32'd1000; rs2_val = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b expected 1", busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
        late_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) late_done++;
            tick();
        end
        checks++; if (late_done != 0) begin errors++; $display("FAIL flush_no_done: got %0d done cycles expected 0", late_done); end
        // flush wins over a simultaneous start
        start = 1'b1; flush = 1'b1; func3 = F_MUL; rs1_val = 32'd9; rs2_val = 32'd9;
        tick();
        start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_start_done: got %b expected 0", done); end
        run_op(F_MUL, 32'd3, 32'd4, d, b, r);
        checks++; if (r !== 32'd12) begin errors++; $display("FAIL flush_next_mul: got %h expected 0000000c", r); end
        checks++; if (d != 2) begin errors++; $display("FAIL flush_next_done_cycle: got %0d expected 2", d); end
        tick();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; func3 = F_DIV; rs1_val = 32'd100; rs2_val = 32'd3;
        tick();
        start = 1'b0;
        repeat (19) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h expected 00000000", result); end
        #2 rst_n = 1'b1;
        tick();
        checks++; if ((busy !== 1'b0) || (done !== 1'b0)) begin errors++; $display("FAIL rstmid_after: got busy=%b done=%b expected 0 0", busy, done); end
        tick();
    endtask

    task automatic test_back_to_back();
        int d1, b1, d2, b2;
        logic [31:0] r1, r2;
        run_op(F_MUL, 32'd123, 32'd456, d1, b1, r1);
        // next start lands in the DONE cycle of the multiply
        run_op(F_DIVU, 32'd1000000, 32'd7, d2, b2, r2);
        checks++; if (r1 !== 32'h0000_DB18) begin errors++; $display("FAIL b2b_mul_result: got %h expected 0000db18", r1); end
        checks++; if (d1 != 2) begin errors++; $display("FAIL b2b_mul_done_cycle: got %0d expected 2", d1); end
        checks++; if (r2 !== 32'h0002_2E09) begin errors++; $display("FAIL b2b_divu_result: got %h expected 00022e09", r2); end
        checks++; if (d2 != 33) begin errors++; $display("FAIL b2b_divu_done_cycle: got %0d expected 33", d2); end
        checks++; if (b2 != 32) begin errors++; $display("FAIL b2b_divu_busy_cycles: got %0d expected 32", b2); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b expected 0", done); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
